ahbl_master_mux: RTL and testbench

AHBL_MASTER_MUX -- requirements
Module: ahbl_master_mux

---
 rtl/ahbl_master_mux.sv | 215 +++++++++++++++++++++
 tb/tb_ahbl_master_mux.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_master_mux.sv
// ahbl_master_mux: shares one AHB-lite slave port between NUM_M AHB-lite masters.
// Each master request is captured into a hold register, arbitrated, then issued
// to the slave so that its address phase overlaps the previous data phase.
module ahbl_master_mux #(
    parameter int unsigned NUM_M    = 2,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [NUM_M*AW-1:0] M_HADDR,
    input  logic [NUM_M*2-1:0]  M_HTRANS,
    input  logic [NUM_M-1:0]    M_HWRITE,
    input  logic [NUM_M*3-1:0]  M_HSIZE,
    input  logic [NUM_M*DW-1:0] M_HWDATA,
    output logic [NUM_M-1:0]    M_HREADY,
    output logic [DW-1:0]       M_HRDATA,
    output logic [AW-1:0]       HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [DW-1:0]       HWDATA,
    input  logic                HREADY,
    input  logic [DW-1:0]       HRDATA,
    output logic [2:0]          HMASTER
);

    localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } mst_state_t;

    mst_state_t        state      [NUM_M];
    logic [AW-1:0]     hold_addr  [NUM_M];
    logic              hold_write [NUM_M];
    logic [2:0]        hold_size  [NUM_M];

    logic [NUM_M-1:0]  req;
    logic [NUM_M-1:0]  waiting;

    logic              lo_valid;
    logic [IW-1:0]     lo_idx;
    logic              hi_valid;
    logic [IW-1:0]     hi_idx;
    logic              arb_valid;
    logic [IW-1:0]     arb_idx;

    logic              sel_valid;
    logic [IW-1:0]     sel_idx;
    logic              issue;

    logic [IW-1:0]     last_winner;
    logic              data_valid;
    logic [IW-1:0]     data_owner;

    // Address phase freeze while the slave stalls
    logic              addr_lock;
    logic              lock_valid;
    logic [IW-1:0]     lock_idx;

    // Decode requests (SEQ counts as NONSEQ; IDLE/BUSY are not requests) and WAIT flags
    always_comb begin
        req     = '0;
        waiting = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            req[i]     = (M_HTRANS[i*2 +: 2] == TRANS_NONSEQ) ||
                         (M_HTRANS[i*2 +: 2] == TRANS_SEQ);
            waiting[i] = (state[i] == ST_WAIT);
        end
    end

    // Lowest waiting index overall, and lowest waiting index above last_winner
    always_comb begin
        lo_valid = 1'b0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        hi_idx   = '0;
        for (int j = int'(NUM_M) - 1; j >= 0; j--) begin
            if (waiting[j]) begin
                lo_valid = 1'b1;
                lo_idx   = IW'(j);
                if (j > int'(last_winner)) begin
                    hi_valid = 1'b1;
                    hi_idx   = IW'(j);
                end
            end
        end
    end

    // Round-robin takes the first waiter after last_winner, wrapping to the lowest
    always_comb begin
        arb_valid = lo_valid;
        arb_idx   = lo_idx;
        if ((ARB_MODE == 1) && (NUM_M > 1) && hi_valid) begin
            arb_idx = hi_idx;
        end
    end

    assign sel_valid = addr_lock ? lock_valid : arb_valid;
    assign sel_idx   = addr_lock ? lock_idx   : arb_idx;
    assign issue     = HREADY && sel_valid;

    // Slave address phase driven from the selected hold register
    always_comb begin
        HTRANS = TRANS_IDLE;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        if (sel_valid) begin
            HTRANS = TRANS_NONSEQ;
            HADDR  = hold_addr[sel_idx];
            HWRITE = hold_write[sel_idx];
            HSIZE  = hold_size[sel_idx];
        end
    end

    // Slave data phase: write data steered from the data-phase owner
    always_comb begin
        HWDATA = '0;
        if (data_valid) begin
            HWDATA = M_HWDATA[DW*32'(data_owner) +: DW];
        end
    end

    assign HMASTER  = 3'(data_owner);
    assign M_HRDATA = HRDATA;

    // Per-master ready: stalled while waiting, follows the slave in the data phase
    always_comb begin
        M_HREADY = '1;
        for (int i = 0; i < int'(NUM_M); i++) begin
            case (state[i])
                ST_WAIT: M_HREADY[i] = 1'b0;
                ST_DATA: M_HREADY[i] = HREADY;
                default: M_HREADY[i] = 1'b1;
            endcase
        end
    end

    // Per-master state machine and hold register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(NUM_M); i++) begin
                state[i]      <= ST_IDLE;
                hold_addr[i]  <= '0;
                hold_write[i] <= 1'b0;
                hold_size[i]  <= 3'd0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_M); i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (req[i]) begin
                            state[i]      <= ST_WAIT;
                            hold_addr[i]  <= M_HADDR[i*AW +: AW];
                            hold_write[i] <= M_HWRITE[i];
                            hold_size[i]  <= M_HSIZE[i*3 +: 3];
                        end
                    end
                    ST_WAIT: begin
                        if (issue && (sel_idx == IW'(i))) begin
                            state[i] <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (HREADY) begin
                            if (req[i]) begin
                                state[i]      <= ST_WAIT;
                                hold_addr[i]  <= M_HADDR[i*AW +: AW];
                                hold_write[i] <= M_HWRITE[i];
                                hold_size[i]  <= M_HSIZE[i*3 +: 3];
                            end else begin
                                state[i] <= ST_IDLE;
                            end
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // Issue bookkeeping and address-phase freeze during slave wait states
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_valid  <= 1'b0;
            data_owner  <= '0;
            last_winner <= IW'(NUM_M - 1);
            addr_lock   <= 1'b0;
            lock_valid  <= 1'b0;
            lock_idx    <= '0;
        end else if (HREADY) begin
            data_valid <= issue;
            addr_lock  <= 1'b0;
            if (issue) begin
                data_owner  <= sel_idx;
                last_winner <= sel_idx;
            end
        end else begin
            addr_lock  <= 1'b1;
            lock_valid <= sel_valid;
            lock_idx   <= sel_idx;
        end
    end

endmodule

// File: tb/tb_ahbl_master_mux.sv
// tb_ahbl_master_mux: directed checks of ahbl_master_mux with a 2-master
// fixed-priority instance and a 3-master round-robin instance.
module tb_ahbl_master_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 2-master, fixed priority
    logic [63:0] m_haddr;
    logic [3:0]  m_htrans;
    logic [1:0]  m_hwrite;
    logic [5:0]  m_hsize;
    logic [63:0] m_hwdata;
    logic [1:0]  m_hready;
    logic [31:0] m_hrdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic [2:0]  hmaster;

    // 3-master, round robin
    logic [95:0] r_haddr;
    logic [5:0]  r_htrans;
    logic [2:0]  r_hwrite;
    logic [8:0]  r_hsize;
    logic [95:0] r_hwdata;
    logic [2:0]  r_hready;
    logic [31:0] r_hrdata;
    logic [31:0] haddr_r;
    logic [1:0]  htrans_r;
    logic        hwrite_r;
    logic [2:0]  hsize_r;
    logic [31:0] hwdata_r;
    logic        hready_r;
    logic [31:0] hrdata_r;
    logic [2:0]  hmaster_r;

    int checks = 0;
    int errors = 0;

    ahbl_master_mux #(.NUM_M(2), .AW(32), .DW(32), .ARB_MODE(0)) dut_fp (
        .HCLK(clk), .HRESETn(rst_n),
        .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(m_hwrite),
        .M_HSIZE(m_hsize), .M_HWDATA(m_hwdata), .M_HREADY(m_hready),
        .M_HRDATA(m_hrdata), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata),
        .HMASTER(hmaster)
    );

    ahbl_master_mux #(.NUM_M(3), .AW(32), .DW(32), .ARB_MODE(1)) dut_rr (
        .HCLK(clk), .HRESETn(rst_n),
        .M_HADDR(r_haddr), .M_HTRANS(r_htrans), .M_HWRITE(r_hwrite),
        .M_HSIZE(r_hsize), .M_HWDATA(r_hwdata), .M_HREADY(r_hready),
        .M_HRDATA(r_hrdata), .HADDR(haddr_r), .HTRANS(htrans_r), .HWRITE(hwrite_r),
        .HSIZE(hsize_r), .HWDATA(hwdata_r), .HREADY(hready_r), .HRDATA(hrdata_r),
        .HMASTER(hmaster_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int idx, input logic [1:0] tr, input logic [31:0] a,
                           input logic w, input logic [31:0] d);
        m_htrans[idx*2 +: 2]  = tr;
        m_haddr[idx*32 +: 32] = a;
        m_hwrite[idx]         = w;
        m_hsize[idx*3 +: 3]   = 3'd2;
        m_hwdata[idx*32 +: 32] = d;
    endtask

    task automatic drive_r(input int idx, input logic [1:0] tr, input logic [31:0] a);
        r_htrans[idx*2 +: 2]  = tr;
        r_haddr[idx*32 +: 32] = a;
        r_hwrite[idx]         = 1'b0;
        r_hsize[idx*3 +: 3]   = 3'd2;
        r_hwdata[idx*32 +: 32] = 32'h0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        m_haddr  = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hwdata = '0;
        hready   = 1'b1; hrdata = '0;
        r_haddr  = '0; r_htrans = '0; r_hwrite = '0; r_hsize = '0; r_hwdata = '0;
        hready_r = 1'b1; hrdata_r = '0;
        #2;
        checks++; if (m_hready !== 2'b11) begin errors++; $display("FAIL reset_m_hready: got %b expected %b", m_hready, 2'b11); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b expected %b", htrans, 2'b00); end
        checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h expected %h", haddr, 32'h0); end
        checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h expected %h", hwdata, 32'h0); end
        checks++; if (hmaster !== 3'd0) begin errors++; $display("FAIL reset_hmaster: got %0d expected %0d", hmaster, 0); end
        checks++; if (r_hready !== 3'b111) begin errors++; $display("FAIL reset_rr_m_hready: got %b expected %b", r_hready, 3'b111); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL post_reset_htrans: got %b expected %b", htrans, 2'b00); end
    endtask

    task automatic test_single();
        drive_m(0, 2'b10, 32'h1000, 1'b1, 32'h0);
        drive_m(1, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (m_hready[0] !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b expected %b", m_hready[0], 1'b1); end
        tick();
        drive_m(0, 2'b00, 32'h1000, 1'b1, 32'hDEADBEEF);
        #1;
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL single_htrans: got %b expected %b", htrans, 2'b10); end
        checks++; if (haddr !== 32'h1000) begin errors++; $display("FAIL single_haddr: got %h expected %h", haddr, 32'h1000); end
        checks++; if (hwrite !== 1'b1) begin errors++; $display("FAIL single_hwrite: got %b expected %b", hwrite, 1'b1); end
        checks++; if (hsize !== 3'd2) begin errors++; $display("FAIL single_hsize: got %0d expected %0d", hsize, 2); end
        checks++; if (m_hready[0] !== 1'b0) begin errors++; $display("FAIL single_wait_ready: got %b expected %b", m_hready[0], 1'b0); end
        tick();
        #1;
        checks++; if (hwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hwdata: got %h expected %h", hwdata, 32'hDEADBEEF); end
        checks++; if (m_hready[0] !== 1'b1) begin errors++; $display("FAIL single_done_ready: got %b expected %b", m_hready[0], 1'b1); end
        checks++; if (hmaster !== 3'd0) begin errors++; $display("FAIL single_hmaster: got %0d expected %0d", hmaster, 0); end
        tick();
        drive_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL single_hwdata_idle: got %h expected %h", hwdata, 32'h0); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL single_htrans_idle: got %b expected %b", htrans, 2'b00); end
    endtask

    task automatic test_fixed_priority();
        drive_m(0, 2'b10, 32'h10, 1'b0, 32'h0);
        drive_m(1, 2'b11, 32'h20, 1'b0, 32'h0);
        tick();
        drive_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drive_m(1, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (haddr !== 32'h10) begin errors++; $display("FAIL fp_first_haddr: got %h expected %h", haddr, 32'h10); end
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL fp_first_htrans: got %b expected %b", htrans, 2'b10); end
        tick();
        checks++; if (haddr !== 32'h20) begin errors++; $display("FAIL fp_second_haddr: got %h expected %h", haddr, 32'h20); end
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL fp_second_htrans: got %b expected %b", htrans, 2'b10); end
        checks++; if (hmaster !== 3'd0) begin errors++; $display("FAIL fp_hmaster0: got %0d expected %0d", hmaster, 0); end
        checks++; if (m_hready !== 2'b01) begin errors++; $display("FAIL fp_ready_mid: got %b expected %b", m_hready, 2'b01); end
        tick();
        hrdata = 32'hCAFEF00D;
        #1;
        checks++; if (hmaster !== 3'd1) begin errors++; $display("FAIL fp_hmaster1: got %0d expected %0d", hmaster, 1); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL fp_htrans_idle: got %b expected %b", htrans, 2'b00); end
        checks++; if (m_hready !== 2'b11) begin errors++; $display("FAIL fp_ready_end: got %b expected %b", m_hready, 2'b11); end
        checks++; if (m_hrdata !== 32'hCAFEF00D) begin errors++; $display("FAIL fp_hrdata: got %h expected %h", m_hrdata, 32'hCAFEF00D); end
        tick();
    endtask

    task automatic test_wait_states();
        drive_m(1, 2'b10, 32'h300, 1'b0, 32'h0);
        tick();
        drive_m(1, 2'b00, 32'h0, 1'b0, 32'h0);
        drive_m(0, 2'b10, 32'h400, 1'b0, 32'h0);
        #1;
        checks++; if (haddr !== 32'h300) begin errors++; $display("FAIL ws_m1_haddr: got %h expected %h", haddr, 32'h300); end
        tick();
        drive_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (haddr !== 32'h400) begin errors++; $display("FAIL ws_frozen_haddr[%0d]: got %h expected %h", k, haddr, 32'h400); end
            checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL ws_frozen_htrans[%0d]: got %b expected %b", k, htrans, 2'b10); end
            checks++; if (m_hready !== 2'b00) begin errors++; $display("FAIL ws_m_hready[%0d]: got %b expected %b", k, m_hready, 2'b00); end
            checks++; if (hmaster !== 3'd1) begin errors++; $display("FAIL ws_hmaster[%0d]: got %0d expected %0d", k, hmaster, 1); end
            tick();
        end
        hready = 1'b1;
        hrdata = 32'h55AA55AA;
        #1;
        checks++; if (m_hrdata !== 32'h55AA55AA) begin errors++; $display("FAIL ws_hrdata: got %h expected %h", m_hrdata, 32'h55AA55AA); end
        checks++; if (m_hready[1] !== 1'b1) begin errors++; $display("FAIL ws_m1_ready: got %b expected %b", m_hready[1], 1'b1); end
        checks++; if (haddr !== 32'h400) begin errors++; $display("FAIL ws_issue_haddr: got %h expected %h", haddr, 32'h400); end
        tick();
        hrdata = 32'h0;
        #1;
        checks++; if (hmaster !== 3'd0) begin errors++; $display("FAIL ws_m0_hmaster: got %0d expected %0d", hmaster, 0); end
        checks++; if (m_hready !== 2'b11) begin errors++; $display("FAIL ws_ready_end: got %b expected %b", m_hready, 2'b11); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL ws_htrans_end: got %b expected %b", htrans, 2'b00); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_m(0, 2'b10, 32'h2000, 1'b1, 32'h0);
        tick();
        drive_m(0, 2'b10, 32'h2004, 1'b1, 32'h11111111);
        #1;
        checks++; if (haddr !== 32'h2000) begin errors++; $display("FAIL b2b_first_haddr: got %h expected %h", haddr, 32'h2000); end
        checks++; if (m_hready[0] !== 1'b0) begin errors++; $display("FAIL b2b_first_wait: got %b expected %b", m_hready[0], 1'b0); end
        tick();
        checks++; if (m_hready[0] !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected %b", m_hready[0], 1'b1); end
        checks++; if (hwdata !== 32'h11111111) begin errors++; $display("FAIL b2b_first_hwdata: got %h expected %h", hwdata, 32'h11111111); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL b2b_gap_htrans: got %b expected %b", htrans, 2'b00); end
        tick();
        drive_m(0, 2'b00, 32'h2004, 1'b1, 32'h22222222);
        #1;
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL b2b_second_htrans: got %b expected %b", htrans, 2'b10); end
        checks++; if (haddr !== 32'h2004) begin errors++; $display("FAIL b2b_second_haddr: got %h expected %h", haddr, 32'h2004); end
        checks++; if (m_hready[0] !== 1'b0) begin errors++; $display("FAIL b2b_rearb_wait: got %b expected %b", m_hready[0], 1'b0); end
        tick();
        checks++; if (hwdata !== 32'h22222222) begin errors++; $display("FAIL b2b_second_hwdata: got %h expected %h", hwdata, 32'h22222222); end
        checks++; if (m_hready[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected %b", m_hready[0], 1'b1); end
        drive_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h100;
        exp_addr[1] = 32'h200;
        exp_addr[2] = 32'h300;
        drive_r(0, 2'b10, 32'h100);
        drive_r(1, 2'b10, 32'h200);
        drive_r(2, 2'b10, 32'h300);
        tick();
        for (int k = 0; k < 6; k++) begin
            checks++; if (htrans_r !== 2'b10) begin errors++; $display("FAIL rr_htrans[%0d]: got %b expected %b", k, htrans_r, 2'b10); end
            checks++; if (haddr_r !== exp_addr[k % 3]) begin errors++; $display("FAIL rr_haddr[%0d]: got %h expected %h", k, haddr_r, exp_addr[k % 3]); end
            if (k > 0) begin
                checks++; if (hmaster_r !== 3'((k - 1) % 3)) begin errors++; $display("FAIL rr_hmaster[%0d]: got %0d expected %0d", k, hmaster_r, (k - 1) % 3); end
            end
            tick();
        end
        drive_r(0, 2'b00, 32'h0);
        drive_r(1, 2'b00, 32'h0);
        drive_r(2, 2'b00, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        checks++; if (r_hready !== 3'b111) begin errors++; $display("FAIL rr_drained_ready: got %b expected %b", r_hready, 3'b111); end
    endtask

    task automatic test_reset_mid();
        drive_m(0, 2'b10, 32'h500, 1'b1, 32'h0);
        drive_m(1, 2'b10, 32'h600, 1'b1, 32'h0);
        tick();
        drive_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drive_m(1, 2'b00, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (m_hready !== 2'b01) begin errors++; $display("FAIL rst_mid_pre_ready: got %b expected %b", m_hready, 2'b01); end
        rst_n = 1'b0;
        #1;
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_mid_htrans: got %b expected %b", htrans, 2'b00); end
        checks++; if (m_hready !== 2'b11) begin errors++; $display("FAIL rst_mid_ready: got %b expected %b", m_hready, 2'b11); end
        checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL rst_mid_haddr: got %h expected %h", haddr, 32'h0); end
        checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL rst_mid_hwdata: got %h expected %h", hwdata, 32'h0); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_mid_after_htrans: got %b expected %b", htrans, 2'b00); end
        drive_m(0, 2'b10, 32'h1000, 1'b1, 32'h0);
        tick();
        drive_m(0, 2'b00, 32'h1000, 1'b1, 32'hDEADBEEF);
        #1;
        checks++; if (haddr !== 32'h1000) begin errors++; $display("FAIL rst_mid_new_haddr: got %h expected %h", haddr, 32'h1000); end
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL rst_mid_new_htrans: got %b expected %b", htrans, 2'b10); end
        tick();
        checks++; if (m_hready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_new_done: got %b expected %b", m_hready[0], 1'b1); end
        checks++; if (hwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mid_new_hwdata: got %h expected %h", hwdata, 32'hDEADBEEF); end
        drive_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_priority();
        test_wait_states();
        test_back_to_back();
        test_round_robin();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
